pu_msp430_dac_spi_rx: RTL and testbench



---
 rtl/pu_msp430_dac_spi_rx_if.sv | 19 +
 rtl/pu_msp430_dac_spi_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_pu_msp430_dac_spi_rx.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pu_msp430_dac_spi_rx_if.sv
// Peripheral bus bundle for the DAC SPI receiver: word address, write data,
// enable and byte write strobes from the CPU side, read data back.
interface pu_msp430_dac_spi_rx_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout
    );
endinterface

// File: rtl/pu_msp430_dac_spi_rx.sv
// DAC serial-link frame receiver: oversamples sclk/sync_n/din on mclk, deserializes
// 16-bit MSB-first frames and exposes value, status and error count on the peripheral bus.
module pu_msp430_dac_spi_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] BASE_ADDR   = 16'h01A0
) (
    input  logic                         mclk,
    input  logic                         puc_rst_n,
    input  logic                         sclk,
    input  logic                         sync_n,
    input  logic                         din,
    pu_msp430_dac_spi_rx_if.slave        per,
    output logic [11:0]                  dac_value,
    output logic [1:0]                   dac_pd,
    output logic                         dac_update,
    output logic                         frame_err,
    output logic                         irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sy_p0;
    logic [SYNC_STAGES-1:0] sync_sy_p0;
    logic [SYNC_STAGES-1:0] din_sy_p0;
    logic                   sclk_hist_p1;
    logic                   sync_hist_p1;
    logic                   sclk_cur;
    logic                   sync_cur;
    logic                   din_cur;
    logic                   sclk_fe;
    logic                   sync_fe;
    logic                   sync_re;

    logic                   shift_p2;
    logic                   sync_fe_p2;
    logic                   sync_re_p2;
    logic                   din_p2;

    state_t                 state;
    logic [15:0]            sr;
    logic [15:0]            sr_next;
    logic [4:0]             bit_cnt;
    logic                   last_bit;
    logic                   complete;
    logic                   abort;

    logic                   new_flag;
    logic                   ien;
    logic                   en;
    logic [7:0]             err_cnt;

    logic                   sel;
    logic                   reg_wr;
    logic                   reg_rd;
    logic [2:0]             reg_off;
    logic                   wr_stat;
    logic                   wr_ctrl;
    logic                   unused_bits;

    // Stage p0: per-input synchronizer chains, idle levels on reset
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            sclk_sy_p0 <= '0;
            sync_sy_p0 <= '1;
            din_sy_p0  <= '0;
        end else begin
            sclk_sy_p0[0] <= sclk;
            sync_sy_p0[0] <= sync_n;
            din_sy_p0[0]  <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sy_p0[i] <= sclk_sy_p0[i-1];
                sync_sy_p0[i] <= sync_sy_p0[i-1];
                din_sy_p0[i]  <= din_sy_p0[i-1];
            end
        end
    end

    assign sclk_cur = sclk_sy_p0[SYNC_STAGES-1];
    assign sync_cur = sync_sy_p0[SYNC_STAGES-1];
    assign din_cur  = din_sy_p0[SYNC_STAGES-1];

    // Stage p1: history flops for edge detection
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            sclk_hist_p1 <= 1'b0;
            sync_hist_p1 <= 1'b1;
        end else begin
            sclk_hist_p1 <= sclk_cur;
            sync_hist_p1 <= sync_cur;
        end
    end

    assign sclk_fe = sclk_hist_p1 & ~sclk_cur;
    assign sync_fe = sync_hist_p1 & ~sync_cur;
    assign sync_re = ~sync_hist_p1 & sync_cur;

    // Stage p2: registered events; a sample counts if sync_n was low up to this fall,
    // so a rise coinciding with the last fall still completes the frame
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            shift_p2   <= 1'b0;
            sync_fe_p2 <= 1'b0;
            sync_re_p2 <= 1'b0;
        end else begin
            shift_p2   <= sclk_fe & ~sync_hist_p1;
            sync_fe_p2 <= sync_fe;
            sync_re_p2 <= sync_re;
        end
    end

    always_ff @(posedge mclk) begin
        din_p2 <= din_cur;
    end

    assign sr_next  = {sr[14:0], din_p2};
    assign last_bit = shift_p2 && (bit_cnt == 5'd15);
    assign complete = en && (state == SHIFT) && last_bit;
    assign abort    = en && (state == SHIFT) && sync_re_p2 && !last_bit;

    // Stage p3: frame state machine and decoded outputs
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state      <= IDLE;
            bit_cnt    <= 5'd0;
            dac_value  <= 12'd0;
            dac_pd     <= 2'd0;
            dac_update <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dac_update <= 1'b0;
            frame_err  <= 1'b0;
            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (sync_fe_p2) begin
                            state   <= SHIFT;
                            bit_cnt <= 5'd0;
                        end
                    end
                    SHIFT: begin
                        if (shift_p2)
                            bit_cnt <= bit_cnt + 5'd1;
                        if (last_bit) begin
                            dac_value  <= sr_next[11:0];
                            dac_pd     <= sr_next[13:12];
                            dac_update <= 1'b1;
                            state      <= sync_re_p2 ? IDLE : DONE;
                        end else if (sync_re_p2) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    DONE: begin
                        if (sync_re_p2)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (state == SHIFT && shift_p2)
            sr <= sr_next;
    end

    assign sel     = per.per_en && (per.per_addr[13:2] == BASE_ADDR[14:3]);
    assign reg_off = {per.per_addr[1:0], 1'b0};
    assign reg_wr  = sel && (|per.per_we);
    assign reg_rd  = sel && !(|per.per_we);
    assign wr_stat = reg_wr && (reg_off == 3'd2);
    assign wr_ctrl = reg_wr && (reg_off == 3'd4);

    // Hardware set of NEW beats a same-cycle clear; counter clear beats increment
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            new_flag <= 1'b0;
            ien      <= 1'b0;
            en       <= 1'b1;
            err_cnt  <= 8'd0;
        end else begin
            if (complete)
                new_flag <= 1'b1;
            else if (wr_stat && per.per_din[1])
                new_flag <= 1'b0;

            if (wr_stat && per.per_din[2])
                err_cnt <= 8'd0;
            else if (abort && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;

            if (wr_ctrl) begin
                ien <= per.per_din[0];
                en  <= per.per_din[1];
            end
        end
    end

    always_comb begin
        per.per_dout = 16'h0000;
        if (reg_rd) begin
            case (reg_off)
                3'd0:    per.per_dout = {2'b00, dac_pd, dac_value};
                3'd2:    per.per_dout = {err_cnt, 5'b00000, 1'b0, new_flag, (state == SHIFT)};
                3'd4:    per.per_dout = {14'd0, en, ien};
                default: per.per_dout = 16'h0000;
            endcase
        end
    end

    assign irq = new_flag & ien;

    assign unused_bits = ^{per.per_din[15:3], sr[15]};

endmodule

// File: tb/tb_pu_msp430_dac_spi_rx.sv
// Bench for the DAC SPI receiver: vector table, hand sequences for corner cases and
// randomized frames checked against a frame-level reference model.
module tb_pu_msp430_dac_spi_rx;

    localparam int          SS   = 2;
    localparam logic [13:0] A_VAL  = 14'h00D0;
    localparam logic [13:0] A_STAT = 14'h00D1;
    localparam logic [13:0] A_CTRL = 14'h00D2;

    logic        mclk = 1'b0;
    logic        puc_rst_n;
    logic        sclk, sync_n, din;
    logic [11:0] dac_value;
    logic [1:0]  dac_pd;
    logic        dac_update, frame_err, irq;

    pu_msp430_dac_spi_rx_if bus();

    pu_msp430_dac_spi_rx #(.SYNC_STAGES(SS), .BASE_ADDR(16'h01A0)) dut (
        .mclk       (mclk),
        .puc_rst_n  (puc_rst_n),
        .sclk       (sclk),
        .sync_n     (sync_n),
        .din        (din),
        .per        (bus),
        .dac_value  (dac_value),
        .dac_pd     (dac_pd),
        .dac_update (dac_update),
        .frame_err  (frame_err),
        .irq        (irq)
    );

    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_errs   = 0;
    int upd_cnt  = 0;
    int ferr_cnt = 0;

    always @(posedge mclk) begin
        if (dac_update) upd_cnt++;
        if (frame_err)  ferr_cnt++;
    end

    // Reference model: what firmware should see, in frame-level terms
    logic [11:0] m_val;
    logic [1:0]  m_pd;
    int          m_err;
    logic        m_new, m_en, m_ien;
    int          m_upd, m_ferr;

    typedef struct {
        logic [15:0] w;
        int          nbits;
        logic [11:0] e_val;
        logic [1:0]  e_pd;
        int          e_err;
        int          e_upd;
    } vec_t;
    vec_t vec[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic model_reset();
        m_val = 12'd0; m_pd = 2'd0; m_err = 0; m_new = 1'b0; m_en = 1'b1; m_ien = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] w, input int n);
        if (m_en) begin
            if (n == 16) begin
                m_val = w[11:0];
                m_pd  = w[13:12];
                m_new = 1'b1;
                m_upd++;
            end else begin
                if (m_err < 255) m_err++;
                m_ferr++;
            end
        end
    endtask

    task automatic rd_addr(input logic [13:0] a, output logic [15:0] d);
        @(negedge mclk);
        bus.per_addr = a;
        bus.per_we   = 2'b00;
        bus.per_en   = 1'b1;
        #1 d = bus.per_dout;
        @(negedge mclk);
        bus.per_en = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d);
        @(negedge mclk);
        bus.per_addr = a;
        bus.per_din  = d;
        bus.per_we   = 2'b11;
        bus.per_en   = 1'b1;
        @(negedge mclk);
        bus.per_en = 1'b0;
        bus.per_we = 2'b00;
        if (a == A_STAT) begin
            if (d[1]) m_new = 1'b0;
            if (d[2]) m_err = 0;
        end
        if (a == A_CTRL) begin
            m_ien = d[0];
            m_en  = d[1];
        end
    endtask

    task automatic spi_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            din  = w[15-i];
            sclk = 1'b1;
            wait_cyc(3);
            sclk = 1'b0;
            wait_cyc(3);
        end
    endtask

    task automatic frame(input logic [15:0] w, input int n);
        sync_n = 1'b0;
        wait_cyc(3);
        spi_bits(w, n);
        sync_n = 1'b1;
        wait_cyc(8);
        model_frame(w, n);
    endtask

    task automatic check_state(input string tag);
        logic [15:0] d;
        chk({tag, " dac_value"}, dac_value, m_val);
        chk({tag, " dac_pd"}, dac_pd, m_pd);
        chk({tag, " irq"}, irq, m_new & m_ien);
        chk({tag, " upd_cnt"}, upd_cnt, m_upd);
        chk({tag, " ferr_cnt"}, ferr_cnt, m_ferr);
        rd_addr(A_STAT, d);
        chk({tag, " RX_STAT"}, d, {m_err[7:0], 5'b0, 1'b0, m_new, 1'b0});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int          u0, f0, lat;
        logic [15:0] w;
        int          n;

        puc_rst_n    = 1'b0;
        sclk         = 1'b0;
        sync_n       = 1'b1;
        din          = 1'b0;
        bus.per_addr = 14'd0;
        bus.per_din  = 16'd0;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
        m_upd = 0; m_ferr = 0;
        model_reset();

        vec[0] = '{16'h2ABC, 16, 12'hABC, 2'd2, 0, 1};
        vec[1] = '{16'h0FFF, 16, 12'hFFF, 2'd0, 0, 1};
        vec[2] = '{16'h3000, 16, 12'h000, 2'd3, 0, 1};
        vec[3] = '{16'h1555,  9, 12'h000, 2'd3, 1, 0};
        vec[4] = '{16'h1234, 16, 12'h234, 2'd1, 1, 1};
        vec[5] = '{16'hC5A7, 16, 12'h5A7, 2'd0, 1, 1};
        vec[6] = '{16'hFFFF,  3, 12'h5A7, 2'd0, 2, 0};
        vec[7] = '{16'h7FFF, 15, 12'h5A7, 2'd0, 3, 0};

        // Reset state
        wait_cyc(3);
        chk("rst dac_value", dac_value, 0);
        chk("rst dac_pd", dac_pd, 0);
        chk("rst dac_update", dac_update, 0);
        chk("rst frame_err", frame_err, 0);
        chk("rst irq", irq, 0);
        chk("rst per_dout", bus.per_dout, 0);
        puc_rst_n = 1'b1;
        wait_cyc(2);
        rd_addr(A_CTRL, d);
        chk("rst RX_CTRL", d, 16'h0002);
        rd_addr(A_STAT, d);
        chk("rst RX_STAT", d, 16'h0000);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            u0 = upd_cnt;
            frame(vec[i].w, vec[i].nbits);
            chk("vec dac_value", dac_value, vec[i].e_val);
            chk("vec dac_pd", dac_pd, vec[i].e_pd);
            chk("vec upd", upd_cnt - u0, vec[i].e_upd);
            rd_addr(A_STAT, d);
            chk("vec err_cnt", d[15:8], vec[i].e_err);
        end
        check_state("vec end");
        wr(A_STAT, 16'h0006);

        // Latency of dac_update from the 16th pin-level sclk fall
        sync_n = 1'b0;
        wait_cyc(3);
        spi_bits(16'h2ABC, 15);
        din  = 1'b0;
        sclk = 1'b1;
        wait_cyc(3);
        sclk = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge mclk);
            if (dac_update && lat == 0) lat = k;
        end
        chk("latency", lat, SS + 2);
        sync_n = 1'b1;
        wait_cyc(8);
        model_frame(16'h2ABC, 16);
        rd_addr(A_VAL, d);
        chk("RX_VAL 2ABC", d, 16'h2ABC);
        check_state("2ABC");

        // Interrupt enable, capture, write-1 clear of NEW
        wr(A_CTRL, 16'h0003);
        frame(16'h0123, 16);
        chk("irq set", irq, 1);
        wr(A_STAT, 16'h0002);
        chk("irq cleared", irq, 0);
        check_state("irq");

        // Aborted frames and counter saturation
        wr(A_CTRL, 16'h0002);
        u0 = upd_cnt;
        f0 = ferr_cnt;
        frame(16'hFFFF, 9);
        chk("abort ferr", ferr_cnt - f0, 1);
        chk("abort no upd", upd_cnt - u0, 0);
        rd_addr(A_STAT, d);
        chk("abort RX_STAT", d, 16'h0100);
        chk("abort keeps value", dac_value, 12'h123);
        for (int i = 0; i < 299; i++) frame(16'h8000, 1);
        rd_addr(A_STAT, d);
        chk("err_cnt saturates", d[15:8], 255);
        check_state("sat");
        wr(A_STAT, 16'h0004);
        rd_addr(A_STAT, d);
        chk("err_cnt cleared", d, 16'h0000);

        // Back-to-back frames, BUSY only inside frames
        u0 = upd_cnt;
        sync_n = 1'b0;
        wait_cyc(3);
        spi_bits(16'h0FFF, 16);
        sync_n = 1'b1;
        wait_cyc(6);
        model_frame(16'h0FFF, 16);
        sync_n = 1'b0;
        wait_cyc(3);
        spi_bits(16'h3000, 8);
        rd_addr(A_STAT, d);
        chk("busy mid-frame", d[0], 1);
        spi_bits(16'h0000, 8);
        sync_n = 1'b1;
        wait_cyc(8);
        model_frame(16'h3000, 16);
        chk("b2b two updates", upd_cnt - u0, 2);
        check_state("b2b");

        // EN cleared mid-frame, then EN set while sync_n already low
        u0 = upd_cnt;
        f0 = ferr_cnt;
        sync_n = 1'b0;
        wait_cyc(3);
        spi_bits(16'hAAAA, 8);
        wr(A_CTRL, 16'h0000);
        spi_bits(16'hAA00, 8);
        sync_n = 1'b1;
        wait_cyc(8);
        sync_n = 1'b0;
        wait_cyc(3);
        wr(A_CTRL, 16'h0002);
        spi_bits(16'h1111, 16);
        sync_n = 1'b1;
        wait_cyc(8);
        chk("en off no ferr", ferr_cnt - f0, 0);
        chk("en off no upd", upd_cnt - u0, 0);
        frame(16'h2222, 16);
        check_state("en");

        // Reset in the middle of a frame
        frame(16'h0000, 4);
        sync_n = 1'b0;
        wait_cyc(3);
        spi_bits(16'hFFFF, 10);
        puc_rst_n = 1'b0;
        sync_n    = 1'b1;
        sclk      = 1'b0;
        wait_cyc(3);
        puc_rst_n = 1'b1;
        model_reset();
        wait_cyc(3);
        chk("mid rst dac_value", dac_value, 0);
        frame(16'h1555, 16);
        check_state("post rst");

        // Address decode
        rd_addr(14'h00D4, d);
        chk("unselected read", d, 0);

        // Randomized frames against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                wr(A_STAT, {13'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0});
            if ($urandom_range(0, 3) == 0)
                wr(A_CTRL, {14'd0, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1))});
            w = 16'($urandom);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
            frame(w, n);
            check_state("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
